// File: rtl/ps2_pkg.sv
// Shared types, constants and helpers for the PS/2 device-to-host frame receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_DATA_BITS = 8;

  // PS/2 uses odd parity: the data bits plus the parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic p);
    return ^{data, p};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Conditions an asynchronous PS/2 clock pin: 2-FF synchroniser, run-length glitch
// filter and a registered one-cycle strobe on each falling edge of the filtered line.
module ps2_line_sync #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic fall_o
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-2:0] hist_q;
  logic [FILTER_LEN-2:0] hist_d;
  logic [FILTER_LEN-1:0] hist_ext;
  logic                  filt_q;
  logic                  filt_d;
  logic                  fall_q;
  logic                  all_low;
  logic                  all_high;

  // The newest synced sample plus FILTER_LEN-1 older ones must all agree before the
  // filtered level moves, so pulses shorter than FILTER_LEN cycles never get through.
  always_comb begin
    hist_ext = {hist_q, sync_q[1]};
    hist_d   = hist_ext[FILTER_LEN-2:0];
    all_low  = !sync_q[1] && (hist_q == '0);
    all_high = sync_q[1] && (hist_q == '1);
    filt_d   = filt_q;
    if (all_low) begin
      filt_d = 1'b0;
    end else if (all_high) begin
      filt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      hist_q <= '1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      hist_q <= hist_d;
      filt_q <= filt_d;
      fall_q <= filt_q & ~filt_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_frame_writer.sv
// PS/2 device-to-host receiver that publishes each good byte on data_out, holding bsy
// high for the whole frame so the reader only ever sees complete bytes.
module ps2_frame_writer
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       bsy,
  output logic       valid,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    dout_q, dout_d;
  logic          bsy_q, bsy_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [1:0]    dsync_q;
  logic          fall;
  logic          din;

  ps2_line_sync #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .line_i(ps2_clk),
    .fall_o(fall)
  );

  assign din = dsync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tmo_d   = '0;
    dout_d  = dout_q;
    bsy_d   = bsy_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall && !din) begin
          state_d = DATA;
          cnt_d   = '0;
          shift_d = '0;
          bsy_d   = 1'b1;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d = {din, shift_q[7:1]};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'(PS2_DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = din;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (din && odd_parity_ok(shift_q, par_q)) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          bsy_d   = 1'b0;
          state_d = IDLE;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        bsy_d   = 1'b0;
      end
    endcase

    // A fall strobe in the same cycle as expiry counts as progress, so it wins.
    if (state_q != IDLE && !fall) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        bsy_d   = 1'b0;
        state_d = IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      dout_q  <= 8'h00;
      bsy_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      dsync_q <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      dout_q  <= dout_d;
      bsy_q   <= bsy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      dsync_q <= {dsync_q[0], ps2_data};
    end
  end

  assign data_out = dout_q;
  assign bsy      = bsy_q;
  assign valid    = valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ps2_frame_writer.sv
// Randomized and directed bench for ps2_frame_writer against a frame-level reference model.
module tb_ps2_frame_writer;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 10000;
  localparam int Q              = 5;
  localparam logic [31:0] EV_ERR = 32'd256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data_out;
  logic       bsy;
  logic       valid;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  model_dout = 8'h00;

  always #5 clk = ~clk;

  ps2_frame_writer #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .data_out(data_out),
    .bsy     (bsy),
    .valid   (valid),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Event monitor: every valid/err strobe must match the next outcome the model predicted.
  logic       bsy_prev = 1'b0;
  logic [7:0] dout_prev = 8'h00;
  logic       rst_prev = 1'b0;
  logic [31:0] ev;
  always @(negedge clk) begin
    if (rst_n && rst_prev) begin
      if (valid || err) begin
        chk("valid_err_excl", {31'd0, valid & err}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_evt", valid ? {24'd0, data_out} : EV_ERR, 32'hFFFF_FFFF);
        end else begin
          ev = exp_q.pop_front();
          chk("evt", valid ? {24'd0, data_out} : EV_ERR, ev);
          chk("bsy_fall_with_evt", {30'd0, bsy_prev, bsy}, 32'd2);
        end
      end
      if (!valid && data_out !== dout_prev) chk("dout_hold", {24'd0, data_out}, {24'd0, dout_prev});
    end
    bsy_prev  = bsy;
    dout_prev = data_out;
    rst_prev  = rst_n;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(Q);
    ps2_clk = 1'b0;
    tick(2 * Q);
    ps2_clk = 1'b1;
    tick(Q);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_qempty"}, exp_q.size(), 32'd0);
    chk({tag, "_bsy"}, {31'd0, bsy}, 32'd0);
    chk({tag, "_dout"}, {24'd0, data_out}, {24'd0, model_dout});
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop_v);
    logic        p;
    logic [10:0] bits;
    int          n;
    p    = (~^b) ^ par_bad;
    bits = {stop_v, p, b, 1'b0};
    if (stop_v && (($countones({b, p}) % 2) == 1)) begin
      exp_q.push_back({24'd0, b});
      model_dout = b;
    end else begin
      exp_q.push_back(EV_ERR);
    end
    ps2_data = 1'b0;
    tick(Q);
    ps2_clk = 1'b0;
    n = 0;
    while (!bsy && n < 20) begin
      tick(1);
      n++;
    end
    chk("bsy_rise_latency_ok", {31'd0, (n >= FILTER_LEN + 2) && (n <= FILTER_LEN + 4)}, 32'd1);
    if (n < 2 * Q) tick(2 * Q - n);
    ps2_clk = 1'b1;
    tick(Q);
    for (int i = 1; i < 11; i++) begin
      send_bit(bits[i]);
      if (i == 9) chk("bsy_mid_frame", {31'd0, bsy}, 32'd1);
    end
    ps2_data = 1'b1;
    tick(4);
    check_idle("frame");
  endtask

  initial begin
    logic [7:0] b;
    int         n;
    int         r;

    #1 rst_n = 1'b0;
    tick(4);
    chk("rst_dout", {24'd0, data_out}, 32'd0);
    chk("rst_bsy", {31'd0, bsy}, 32'd0);
    chk("rst_valid_err", {30'd0, valid, err}, 32'd0);
    rst_n = 1'b1;
    tick(4);

    send_frame(8'h15, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);

    // Start plus four data bits, then silence until the frame times out.
    exp_q.push_back(EV_ERR);
    send_bit(1'b0);
    b = 8'hA7;
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    ps2_data = b[3];
    tick(Q);
    ps2_clk = 1'b0;
    n = 0;
    while (!err && n < TIMEOUT_CYCLES + 100) begin
      tick(1);
      n++;
      if (n == 2 * Q) ps2_clk = 1'b1;
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    chk("timeout_latency_ok",
        {31'd0, (n >= TIMEOUT_CYCLES + FILTER_LEN + 2) && (n <= TIMEOUT_CYCLES + FILTER_LEN + 4)},
        32'd1);
    tick(3);
    check_idle("timeout");
    send_frame(8'hF0, 1'b0, 1'b1);

    ps2_clk = 1'b0;
    tick(2);
    ps2_clk = 1'b1;
    tick(12);
    check_idle("glitch");
    send_bit(1'b1);
    tick(8);
    check_idle("start_high");

    b = 8'h3B;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", {24'd0, data_out}, 32'd0);
    chk("midrst_bsy", {31'd0, bsy}, 32'd0);
    chk("midrst_valid_err", {30'd0, valid, err}, 32'd0);
    model_dout = 8'h00;
    ps2_data = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    send_frame(8'h1C, 1'b0, 1'b1);

    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h15, 1'b0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (r < 7) begin
        send_frame(b, 1'b0, 1'b1);
      end else if (r == 7) begin
        send_frame(b, 1'b1, 1'b1);
      end else if (r == 8) begin
        send_frame(b, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        send_bit(1'b1);
        tick(8);
        check_idle("rand_start_high");
      end
      tick(int'($urandom_range(0, 8)));
    end

    tick(20);
    check_idle("final");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
